// File: rtl/regfile_init_seq.sv
// Write-port front end for the register file: loads Xi = i + INIT_OFFSET into X0..X30 after reset or reinit, then forwards writebacks.
// Define REGFILE_INIT_CHECK_EN to add a readback verify pass (CHECK) between initialisation and RUN.
module regfile_init_seq #(
  parameter int           N           = 64,
  parameter int           NREG        = 32,
  parameter logic [N-1:0] INIT_OFFSET = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wb_we,
  input  logic [4:0]   wb_wa,
  input  logic [N-1:0] wb_wd,
  input  logic         reinit,
  output logic         we3,
  output logic [4:0]   wa3,
  output logic [N-1:0] wd3,
  output logic         stall,
  output logic         init_done,
  output logic         wb_drop,
  output logic [4:0]   ra_chk,
  input  logic [N-1:0] rd_chk,
  output logic         chk_err
);

  typedef enum logic [1:0] {ST_INIT, ST_CHECK, ST_RUN} state_t;

  localparam logic [4:0] LAST_INIT = 5'(NREG - 2);
  localparam logic [4:0] XZR       = 5'(NREG - 1);

  state_t       st, st_nxt;
  logic [4:0]   idx, idx_nxt;
  logic         init_done_nxt, wb_drop_nxt;
  logic [N-1:0] idx_val;

  assign idx_val = {{(N-5){1'b0}}, idx} + INIT_OFFSET;

`ifdef REGFILE_INIT_CHECK_EN
  logic         chk_fail;
  logic [N-1:0] chk_exp;

  // XZR is never written, so the regfile must read it back as zero.
  assign chk_exp = (idx == XZR) ? '0 : idx_val;
`endif

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and checked first.
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= ST_INIT;
      idx       <= '0;
      init_done <= 1'b0;
      wb_drop   <= 1'b0;
    end else begin
      st        <= st_nxt;
      idx       <= idx_nxt;
      init_done <= init_done_nxt;
      wb_drop   <= wb_drop_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a latch behind.
  always_comb begin
    st_nxt        = st;
    idx_nxt       = idx;
    init_done_nxt = init_done;
    wb_drop_nxt   = wb_drop;
    we3           = 1'b0;
    wa3           = '0;
    wd3           = '0;
    stall         = 1'b1;
    ra_chk        = '0;
`ifdef REGFILE_INIT_CHECK_EN
    chk_fail      = 1'b0;
`endif

    case (st)
      ST_INIT: begin
        we3     = 1'b1;
        wa3     = idx;
        wd3     = idx_val;
        idx_nxt = idx + 5'd1;
        if (idx == LAST_INIT) begin
          idx_nxt = '0;
`ifdef REGFILE_INIT_CHECK_EN
          st_nxt  = ST_CHECK;
`else
          st_nxt        = ST_RUN;
          init_done_nxt = 1'b1;
`endif
        end
      end
`ifdef REGFILE_INIT_CHECK_EN
      ST_CHECK: begin
        ra_chk   = idx;
        chk_fail = (rd_chk != chk_exp);
        idx_nxt  = idx + 5'd1;
        if (idx == XZR) begin
          idx_nxt       = '0;
          st_nxt        = ST_RUN;
          init_done_nxt = 1'b1;
        end
      end
`endif
      ST_RUN: begin
        stall = 1'b0;
        we3   = wb_we & (wb_wa != XZR);
        wa3   = wb_wa;
        wd3   = wb_wd;
        // The same-cycle writeback above still lands; the restart takes effect next cycle.
        if (reinit) begin
          st_nxt        = ST_INIT;
          idx_nxt       = '0;
          init_done_nxt = 1'b0;
        end
      end
      default: begin
        st_nxt  = ST_INIT;
        idx_nxt = '0;
      end
    endcase

    if (stall && wb_we) wb_drop_nxt = 1'b1;

    if (reset) begin
      we3    = 1'b0;
      wa3    = '0;
      wd3    = '0;
      stall  = 1'b1;
      ra_chk = '0;
    end
  end

`ifdef REGFILE_INIT_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)         chk_err <= 1'b0;
    else if (chk_fail) chk_err <= 1'b1;
  end
`else
  logic unused_rd_chk;

  assign chk_err       = 1'b0;
  assign unused_rd_chk = ^rd_chk;
`endif

endmodule
